bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_seq_ctrl_pkg.sv | 25 ++
 rtl/bcd_digit_scan.sv | 53 +++++
 rtl/bcd_seq_ctrl.sv | 112 +++++++++++
 tb/tb_bcd_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_ctrl_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, iteration count, clamp limit and the
// shift-add-3 step used by each conversion iteration.
package bcd_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ITER_COUNT = 7;   // one iteration per input bit
    localparam int BCD_MAX    = 99;  // largest value two BCD digits can show

    // One double-dabble iteration on {tens[14:11], ones[10:7], bin[6:0]}:
    // correct the ones nibble, then the tens nibble, then shift left.
    function automatic logic [14:0] dabble_step(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_digit_scan.sv
// Two-digit multiplexed display scan: drives one digit for REFRESH_DIV
// cycles, then the other. Ports: clk, reset, tens/ones in; an (active-low
// enables, bit1 = tens) and digit_bcd out. Free-running, no handshake.
module bcd_digit_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [1:0] an,
    output logic [3:0] digit_bcd
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    // A blanked tens digit turns both enables off but keeps digit_bcd
    // reporting the tens value.
    always_comb begin
        if (!sel_q) begin
            an        = 2'b10;
            digit_bcd = ones;
        end else begin
            an        = (BLANK_LZ && tens == 4'd0) ? 2'b11 : 2'b01;
            digit_bcd = tens;
        end
    end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential 7-bit binary to 2-digit BCD converter with clamp at 99 and a
// multiplexed display scan. Ports: in_valid/in_data/in_ready request side,
// out_valid pulse, held tens/ones/ovf result, an/digit_bcd display drive.
module bcd_seq_ctrl
    import bcd_seq_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [6:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       ovf,
    output logic [1:0] an,
    output logic [3:0] digit_bcd
);

    localparam logic [2:0] ITER_LAST = 3'(ITER_COUNT - 1);
    localparam logic [6:0] CLAMP_VAL = 7'(BCD_MAX);

    state_t      state_q, state_d;
    logic [14:0] shift_q, shift_d;
    logic [2:0]  iter_q, iter_d;
    logic        ovf_cap_q, ovf_cap_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        ovf_q, ovf_d;
    logic [14:0] shift_step;
    logic        over;

    assign shift_step = dabble_step(shift_q);
    assign over       = (in_data > CLAMP_VAL);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        iter_d    = iter_q;
        ovf_cap_d = ovf_cap_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = CONV;
                    shift_d   = {8'b0, (over ? CLAMP_VAL : in_data)};
                    ovf_cap_d = over;
                    iter_d    = '0;
                end
            end
            CONV: begin
                shift_d = shift_step;
                iter_d  = iter_q + 3'd1;
                // Result registers only change here, so the display keeps
                // the previous result for the whole conversion.
                if (iter_q == ITER_LAST) begin
                    state_d = DONE;
                    iter_d  = '0;
                    tens_d  = shift_step[14:11];
                    ones_d  = shift_step[10:7];
                    ovf_d   = ovf_cap_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            iter_q    <= '0;
            ovf_cap_q <= 1'b0;
            tens_q    <= '0;
            ones_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            iter_q    <= iter_d;
            ovf_cap_q <= ovf_cap_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign tens      = tens_q;
    assign ones      = ones_q;
    assign ovf       = ovf_q;

    bcd_digit_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_LZ    (BLANK_LZ)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .tens      (tens_q),
        .ones      (ones_q),
        .an        (an),
        .digit_bcd (digit_bcd)
    );

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
module tb_bcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready, out_valid, ovf;
    logic [3:0] tens, ones, digit_bcd;
    logic [1:0] an;

    bcd_seq_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .tens      (tens),
        .ones      (ones),
        .ovf       (ovf),
        .an        (an),
        .digit_bcd (digit_bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       v;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result_tens", {28'd0, tens}, {28'd0, e.t});
                check("result_ones", {28'd0, ones}, {28'd0, e.o});
                check("result_ovf", {31'd0, ovf}, {31'd0, e.v});
                check("result_latency", cyc, e.cyc);
                check("ready_low_in_done", {31'd0, in_ready}, 0);
            end
        end
    end

    // Drive one request, wait for acceptance, push the reference result.
    // Reference model: clamp to 99, then split into decimal digits.
    task automatic send(input int v);
        int   k;
        int   m;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 7'(v);
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        m     = (v > 99) ? 99 : v;
        e.t   = 4'(m / 10);
        e.o   = 4'(m % 10);
        e.v   = (v > 99);
        e.cyc = cyc + 8;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Sample 16 cycles, find a select change, then require 4-cycle phases.
    task automatic scan_check(input logic [3:0] et, input logic [3:0] eo);
        logic [1:0] an_s[16];
        logic [3:0] dg_s[16];
        int         f;
        logic       p0, p;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            an_s[i] = an;
            dg_s[i] = digit_bcd;
        end
        f = -1;
        for (int i = 1; i <= 4; i++)
            if (f < 0 && an_s[i] != an_s[i-1]) f = i;
        if (f < 0) begin
            check("scan_no_toggle", 0, 1);
        end else begin
            p0 = (an_s[f] != 2'b10);
            for (int k = 0; k < 8; k++) begin
                p = p0 ^ ((k / 4) % 2 == 1);
                if (!p) begin
                    check("scan_an_ones", {30'd0, an_s[f+k]}, 2);
                    check("scan_digit_ones", {28'd0, dg_s[f+k]}, {28'd0, eo});
                end else begin
                    check("scan_an_tens", {30'd0, an_s[f+k]}, (et == 0) ? 3 : 1);
                    check("scan_digit_tens", {28'd0, dg_s[f+k]}, {28'd0, et});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_tens", {28'd0, tens}, 0);
        check("rst_ones", {28'd0, ones}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_an", {30'd0, an}, 2);
        @(negedge clk);
        reset = 1'b0;

        // Nominal, clamp, exact limit
        send(42);  drain();
        check("hold_tens_42", {28'd0, tens}, 4);
        check("hold_ones_42", {28'd0, ones}, 2);
        send(127); drain();
        send(99);  drain();

        // Busy: second request held while the first converts
        send(7);
        send(55);
        drain();

        // Reset during iteration 4 aborts the conversion
        @(negedge clk);
        check("pre_abort_ready", {31'd0, in_ready}, 1);
        in_valid = 1'b1;
        in_data  = 7'd63;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("held_tens_mid_conv", {28'd0, tens}, 5);
        check("held_ones_mid_conv", {28'd0, ones}, 5);
        check("busy_ready_low", {31'd0, in_ready}, 0);
        #1 reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, in_ready}, 1);
        check("abort_tens", {28'd0, tens}, 0);
        check("abort_ones", {28'd0, ones}, 0);
        check("abort_an", {30'd0, an}, 2);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_abort_tens", {28'd0, tens}, 0);
        check("post_abort_ones", {28'd0, ones}, 0);

        // Display scan with blanked and unblanked tens
        send(5);  drain();
        scan_check(4'd0, 4'd5);
        send(35); drain();
        scan_check(4'd3, 4'd5);

        // Every input value, back to back
        for (int v = 0; v < 128; v++) send(v);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
